ps2_host_transmitter: RTL and testbench
=======================================

// Module: ps2_host_transmitter
// PURPOSE
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//   (e.g. LED set 0xED, reset 0xFF) over the open-collector PS/2 clock/data lines.
//   It generates the parity bit and checks the device ACK. It is the transmit-side
//   counterpart of the scan-code receive path and its parity checker.
// PARAMETERS
//   INHIBIT_CYCLES  5000    clk cycles to hold ps2 clock low before start (100us @50MHz)
//   TIMEOUT_CYCLES  750000  max clk cycles between device clock edges (15ms @50MHz)
//   ODD_PARITY      1       1: parity = ~^data (PS/2 odd); 0: parity = ^data
// PORTS
//   clk           in   1  system clock
//   reset         in   1  asynchronous, active-high reset
//   tx_data       in   8  byte to send, captured on accepted tx_start
//   tx_start      in   1  request; accepted only when tx_busy=0
//   tx_busy       out  1  high from cycle after acceptance until tx_done cycle
//   tx_done       out  1  one-cycle pulse at end of transfer (success or failure)
//   tx_error      out  1  valid with tx_done: 1 = no ACK or timeout
//   ps2_clk_in    in   1  raw PS/2 clock line (async)
//   ps2_data_in   in   1  raw PS/2 data line (async)
//   ps2_clk_oe    out  1  1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe   out  1  1 = pull PS/2 data low, 0 = release
// BEHAVIOUR
//   Reset (async): state IDLE; all outputs 0; both lines released immediately.
//   Inputs: 2-FF synchronised. Device falling edge = sync clk 1->0, one-cycle strobe.
//   FSM states: IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE, DONE.
//   IDLE: tx_start=1 -> latch tx_data, compute parity, go to INHIBIT.
//     tx_start during busy is ignored; there is no queueing.
//   INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
//   REQ: clk_oe=1 and data_oe=1 (start bit 0) for 1 cycle.
//     Next: clk_oe=0, data_oe held at 1, bit index=0, go to SEND.
//   SEND: on each device falling edge, index i drives data_oe:
//     i=0..7 -> ~tx_data[i] (LSB first); i=8 -> ~parity; i=9 -> 0 (stop bit, released).
//     After the i=9 edge, go to WAIT_ACK.
//   WAIT_ACK: on next falling edge, sample sync data; 0 = ACK, 1 = ack error.
//     Go to WAIT_IDLE.
//   WAIT_IDLE: wait until sync clk=1 and sync data=1, then go to DONE.
//   DONE: tx_done=1 for one cycle; tx_error = ack error or timeout; tx_busy=0 in
//     this same cycle; return to IDLE. tx_start is accepted again from the next cycle.
//   Timeout: counter clears on entry to SEND and on every falling edge.
//     If it reaches TIMEOUT_CYCLES in SEND, WAIT_ACK or WAIT_IDLE: release both lines,
//     set error, go to DONE.
//   Lines released (oe=0) in IDLE, DONE, after timeout and during reset.
//   Never drive clk_oe outside INHIBIT and REQ.
//   Reset mid-transfer: abort, no tx_done pulse.
//   Counters are sized by $clog2 of their parameter and must not wrap.
// TESTING
//   1. Send 0xED; device model clocks and ACKs -> data bits 1,0,1,1,0,1,1,1 (LSB first),
//      parity 1, stop 1; tx_done=1, tx_error=0.
//   2. Send 0xFF with ODD_PARITY=1 -> parity bit 1; send 0x00 -> parity bit 1.
//      Same bytes with ODD_PARITY=0 -> parity bits 0 and 0.
//   3. Device holds data high on the ACK edge -> tx_done=1, tx_error=1, both lines released.
//   4. Device stops clocking after bit 3 -> TIMEOUT_CYCLES later tx_done=1, tx_error=1,
//      oe=0; next tx_start is accepted.
//   5. Check clk_oe is high for exactly INHIBIT_CYCLES+1 cycles; data_oe rises in the
//      REQ cycle. Second tx_start while busy -> ignored, exactly one transfer occurs.
//   6. Assert reset in the middle of SEND -> clk_oe=data_oe=tx_busy=0 within reset
//      assertion, no tx_done; a fresh 0xF4 transfer then completes cleanly.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte with
// parity and stop bit on device-generated clocks, then checks the device ACK.
module ps2_host_transmitter #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter bit ODD_PARITY     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE, DONE
   } state_t;

   state_t state, state_nx;

   logic [2:0]       clk_sync;
   logic [1:0]       data_sync;
   logic             clk_s, data_s, fall;
   logic [INH_W-1:0] inh_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [3:0]       bit_idx;
   logic [7:0]       shreg;
   logic             par;
   logic             data_drv;
   logic             err;
   logic             active;
   logic             timeout;
   logic             nxt_bit;

   // Idle bus reads high, so the synchronisers reset to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fall   = clk_sync[2] & ~clk_sync[1];

   assign active  = (state == SEND) || (state == WAIT_ACK) ||
                    (state == WAIT_IDLE);
   assign timeout = active && (tmo_cnt == TMO_MAX);

   assign nxt_bit = (bit_idx < 4'd8)  ? ~shreg[bit_idx[2:0]] :
                    (bit_idx == 4'd8) ? ~par : 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      tx_busy     = 1'b0;
      tx_done     = 1'b0;
      tx_error    = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_start) state_nx = INHIBIT;
         end
         INHIBIT: begin
            tx_busy    = 1'b1;
            ps2_clk_oe = 1'b1;
            if (inh_cnt == INH_LAST) state_nx = REQ;
         end
         REQ: begin
            tx_busy     = 1'b1;
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            state_nx    = SEND;
         end
         SEND: begin
            tx_busy     = 1'b1;
            ps2_data_oe = data_drv;
            if (timeout)                        state_nx = DONE;
            else if (fall && bit_idx == 4'd9)   state_nx = WAIT_ACK;
         end
         WAIT_ACK: begin
            tx_busy = 1'b1;
            if (timeout)   state_nx = DONE;
            else if (fall) state_nx = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            tx_busy = 1'b1;
            if (timeout)             state_nx = DONE;
            else if (clk_s && data_s) state_nx = DONE;
         end
         DONE: begin
            tx_done  = 1'b1;
            tx_error = err;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inh_cnt  <= '0;
         tmo_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         data_drv <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (state == IDLE && tx_start) begin
            shreg   <= tx_data;
            par     <= ODD_PARITY ? ~^tx_data : ^tx_data;
            err     <= 1'b0;
            inh_cnt <= '0;
         end
         if (state == INHIBIT) inh_cnt <= inh_cnt + 1'b1;
         if (state == REQ) begin
            data_drv <= 1'b1;
            bit_idx  <= '0;
            tmo_cnt  <= '0;
         end
         // Saturating watchdog, restarted by every device clock edge.
         if (active) begin
            if (fall)                    tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (timeout) begin
            err      <= 1'b1;
            data_drv <= 1'b0;
         end else if (fall && state == SEND) begin
            data_drv <= nxt_bit;
            bit_idx  <= bit_idx + 4'd1;
         end else if (fall && state == WAIT_ACK) begin
            err <= data_s;
         end
         if (state == DONE) data_drv <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: two instances (odd/even parity) driven by a
// behavioural PS/2 device model that clocks frames in and answers with ACK.
module tb_ps2_host_transmitter;

   localparam int INH = 20;
   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] start = '0;
   logic [7:0] txd [2];
   logic [1:0] dev_clk = '1;
   logic [1:0] dev_data = '1;
   wire  [1:0] busy, done, err, clk_oe, data_oe;
   wire  [1:0] clk_line, data_line;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt [2] = '{0, 0};
   bit err_at [2];
   bit rel_at [2];
   logic [9:0] last_frame;

   assign clk_line  = dev_clk & ~clk_oe;
   assign data_line = dev_data & ~data_oe;

   always #5 clk = ~clk;

   ps2_host_transmitter #(
      .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .ODD_PARITY(1'b1)
   ) u_odd (
      .clk(clk), .reset(reset), .tx_data(txd[0]), .tx_start(start[0]),
      .tx_busy(busy[0]), .tx_done(done[0]), .tx_error(err[0]),
      .ps2_clk_in(clk_line[0]), .ps2_data_in(data_line[0]),
      .ps2_clk_oe(clk_oe[0]), .ps2_data_oe(data_oe[0])
   );

   ps2_host_transmitter #(
      .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .ODD_PARITY(1'b0)
   ) u_even (
      .clk(clk), .reset(reset), .tx_data(txd[1]), .tx_start(start[1]),
      .tx_busy(busy[1]), .tx_done(done[1]), .tx_error(err[1]),
      .ps2_clk_in(clk_line[1]), .ps2_data_in(data_line[1]),
      .ps2_clk_oe(clk_oe[1]), .ps2_data_oe(data_oe[1])
   );

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (done[s] === 1'b1) begin
            done_cnt[s]++;
            err_at[s] = err[s];
            rel_at[s] = !clk_oe[s] && !data_oe[s] && !busy[s];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Instance 0 uses odd parity, instance 1 even parity.
   function automatic logic ref_par(input int s, input logic [7:0] b);
      int ones;
      ones = $countones(b);
      return (s == 0) ? (ones % 2 == 0) : (ones % 2 == 1);
   endfunction

   task automatic start_tx(input int s, input logic [7:0] b);
      @(negedge clk);
      txd[s]   = b;
      start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
   endtask

   task automatic dev_xfer(input int s, input int pulses, input bit ack,
                           output logic [9:0] fr, output logic sb,
                           output int il, output int ro, output bit ok);
      int n;
      n = 0; fr = '0; sb = 1'b1; il = 0; ro = -1; ok = 1'b1;
      while (!clk_oe[s] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!clk_oe[s]) begin
         ok = 1'b0;
         return;
      end
      while (clk_oe[s] && il < 1000) begin
         if (data_oe[s] && ro < 0) ro = il;
         il++;
         @(negedge clk);
      end
      sb = data_line[s];
      repeat (5) @(negedge clk);
      for (int p = 0; p < pulses; p++) begin
         if (p == 10) begin
            dev_data[s] = ack ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
         end
         dev_clk[s] = 1'b0;
         repeat (8) @(negedge clk);
         dev_clk[s] = 1'b1;
         if (p < 10) fr[p] = data_line[s];
         repeat (8) @(negedge clk);
      end
      dev_data[s] = 1'b1;
   endtask

   task automatic wait_done(input int s, input int d0, input int bound,
                            output int w);
      w = 0;
      while (done_cnt[s] == d0 && w < bound) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic run(input int s, input logic [7:0] b, input bit ack,
                      input int pulses, input bit chk_inh);
      int d0, w, il, ro;
      logic [9:0] fr;
      logic sb;
      bit ok;
      d0 = done_cnt[s];
      start_tx(s, b);
      chk("busy_after_start", busy[s], 1);
      dev_xfer(s, pulses, ack, fr, sb, il, ro, ok);
      chk("dev_handshake", ok, 1);
      if (chk_inh) begin
         chk("inhibit_len", il, INH + 1);
         chk("req_offset", ro, INH);
      end
      chk("start_bit", sb, 0);
      if (pulses >= 11) chk("frame", fr, {1'b1, ref_par(s, b), b});
      else              chk("partial_bits", fr[3:0], b[3:0]);
      wait_done(s, d0, TMO + 100, w);
      chk("done_count", done_cnt[s] - d0, 1);
      if (pulses < 11)
         chk("timeout_window", (w >= TMO - 30 && w <= TMO + 10), 1);
      chk("tx_error", err_at[s], (pulses < 11) || !ack);
      chk("lines_released", rel_at[s], 1);
      last_frame = fr;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int d0, w, il, ro, seen;
      logic [9:0] fr;
      logic sb;
      bit ok;
      txd[0] = '0;
      txd[1] = '0;

      repeat (3) @(negedge clk);
      chk("rst_clk_oe", clk_oe, 0);
      chk("rst_data_oe", data_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", err, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      run(0, 8'hED, 1'b1, 11, 1'b1);
      chk("ed_bits", last_frame, 10'b11_1110_1101);

      run(0, 8'hFF, 1'b1, 11, 1'b1);
      chk("par_ff_odd", last_frame[8], 1);
      run(0, 8'h00, 1'b1, 11, 1'b1);
      chk("par_00_odd", last_frame[8], 1);
      run(1, 8'hFF, 1'b1, 11, 1'b1);
      chk("par_ff_even", last_frame[8], 0);
      run(1, 8'h00, 1'b1, 11, 1'b1);
      chk("par_00_even", last_frame[8], 0);

      run(0, 8'hA5, 1'b0, 11, 1'b0);

      run(0, 8'h3C, 1'b1, 4, 1'b0);
      repeat (10) @(negedge clk);
      chk("oe_after_timeout", {clk_oe[0], data_oe[0]}, 0);
      run(0, 8'h55, 1'b1, 11, 1'b1);

      d0 = done_cnt[0];
      start_tx(0, 8'hED);
      @(negedge clk);
      start_tx(0, 8'h12);
      chk("busy_ignores_start", busy[0], 1);
      dev_xfer(0, 11, 1'b1, fr, sb, il, ro, ok);
      chk("dbl_handshake", ok, 1);
      chk("dbl_frame", fr, {1'b1, ref_par(0, 8'hED), 8'hED});
      wait_done(0, d0, TMO + 100, w);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (clk_oe[0] || busy[0]) seen++;
      end
      chk("dbl_no_second", seen, 0);
      chk("dbl_done_count", done_cnt[0] - d0, 1);

      d0 = done_cnt[0];
      start_tx(0, 8'h99);
      dev_xfer(0, 4, 1'b1, fr, sb, il, ro, ok);
      chk("rst_mid_busy", busy[0], 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_outputs", {clk_oe[0], data_oe[0], busy[0]}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_mid_no_done", done_cnt[0] - d0, 0);
      run(0, 8'hF4, 1'b1, 11, 1'b1);

      for (int k = 0; k < 6; k++) begin
         run(int'($urandom_range(0, 1)), 8'($urandom),
             $urandom_range(0, 3) != 0, 11, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
